rr_prio_encoder: RTL
====================

RR_PRIO_ENCODER -- requirements
Module: rr_prio_encoder

Interface
REQ-001 SHALL have parameter N, default 8, number of request inputs; legal range 2..64.
REQ-002 SHALL have parameter MODE, default 0; 0 = fixed priority, 1 = round-robin.
REQ-003 SHALL have derived localparam W = clog2(N), the index width; it SHALL NOT be overridable.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 req  in  N  request vector; any number of bits may be set.
REQ-007 out_valid  out  1  a captured winner is presented.
REQ-008 out_ready  in  1  consumer accepts the winner when out_valid=1.
REQ-009 out_idx  out  W  binary index of the winner.
REQ-010 out_onehot  out  N  one-hot form of out_idx; all zeros when out_valid=0.
REQ-011 out_multi  out  1  more than one req bit was set at capture.

Function
REQ-012 SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 IDLE with |req=1 at an edge: SHALL capture the winner, move to HOLD, and assert out_valid on the following cycle (latency 1).
REQ-014 IDLE with req=0: SHALL stay in IDLE with outputs unchanged at their reset values.
REQ-015 MODE=0: winner SHALL be the highest set index of req.
REQ-016 MODE=1: winner SHALL be the first set index found searching upward from (ptr+1) mod N, wrapping past N-1 to 0.
REQ-017 ptr SHALL update to out_idx on every accept (out_valid & out_ready); in MODE=0 ptr is unused.
REQ-018 In HOLD, out_idx, out_onehot and out_multi SHALL stay stable until accept, regardless of req changes.
REQ-019 Accept with |req=1 in the same cycle: SHALL capture a new winner at that edge and stay in HOLD, giving one grant per cycle.
REQ-020 For a same-cycle recapture in MODE=1, the search SHALL start from (out_idx+1) mod N, using the pointer value being written.
REQ-021 Accept with req=0: SHALL return to IDLE and clear out_valid, out_idx, out_onehot and out_multi on the next cycle.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 out_multi SHALL be 1 exactly when popcount(req) >= 2 at the capture edge.
REQ-024 A single set bit SHALL win in both modes with out_multi=0.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_idx=0, out_onehot=0, out_multi=0 and ptr=N-1, even mid-HOLD.
REQ-026 On reset release, the first capture SHALL occur no earlier than the first rising edge with rst_n=1.
REQ-027 After reset, the first MODE=1 search SHALL therefore start at index 0.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/HOLD) and the MODE constants (MODE_FIXED=0, MODE_RR=1).
REQ-029 The winner search SHALL be a combinational sub-module prio_pick with ports: vector in, start index in, wrap-enable in, index out, found out.
REQ-030 In MODE=0, prio_pick SHALL be used with no wrap and a top-down search.
REQ-031 The top level SHALL contain only the FSM, the output registers and ptr.

Verification (N=8)
REQ-032 Reset, then req=0 for 10 cycles -> out_valid stays 0 and all outputs are 0.
REQ-033 MODE=0, req=8'b0010_0110 with out_ready=1 held -> out_idx=5, out_multi=1 one cycle later, and out_idx=5 repeats each cycle while req is held.
REQ-034 MODE=0, each one-hot req 8'b0000_0001..8'b1000_0000 in turn -> out_idx=0..7, out_onehot equals req, out_multi=0.
REQ-035 MODE=1, req=8'b1000_0101 held, out_ready=1 -> grant sequence 0,2,7,0,2 on consecutive cycles (wrap-around).
REQ-036 MODE=1, req=8'b0001_1000 with out_ready=0 for 5 cycles, then req changes -> out_idx stays 3 until accept; after accept the next winner is searched from index 4.
REQ-037 Assert rst_n=0 mid-HOLD with out_idx=6 -> out_valid=0 without waiting for a clock edge; after release, MODE=1 with req=8'b1100_0000 -> out_idx=6.

Source files
------------

// File: rtl/rr_prio_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_prio_encoder_pkg
// Purpose : Shared constants for the priority encoder slice: FSM state
//           encoding and the arbitration mode selectors.
// Revision: 1.0 - initial release
// ============================================================================
package rr_prio_encoder_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Arbitration modes
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage : rr_prio_encoder_pkg
`default_nettype wire

// File: rtl/rr_prio_encoder_prio_pick.sv
`default_nettype none
// ============================================================================
// Module  : prio_pick
// Purpose : Combinational winner search over a request vector.
//           wrap_i=1 : first set bit searching upward from start_i, wrapping
//                      past N-1 back to 0.
//           wrap_i=0 : highest set bit at or below start_i (top-down, no wrap).
// Revision: 1.0 - initial release
// ============================================================================
module prio_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  input  logic         wrap_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Doubling the vector lets a plain right shift act as a rotation, so bit k
  // of w_rot is request (start_i + k) mod N.
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  assign w_dbl = {vec_i, vec_i};
  assign w_rot = N'(w_dbl >> start_i);

  // Scan the candidates; later loop iterations override earlier ones, so the
  // loop order decides which set bit wins.
  always_comb begin
    logic [W:0] w_sum;
    idx_o   = '0;
    found_o = 1'b0;
    w_sum   = '0;
    if (wrap_i) begin
      // Descending offset: the smallest offset from start_i wins.
      for (int k = N - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_sum = {1'b0, start_i} + (W+1)'(k);
          if (w_sum >= (W+1)'(N)) begin
            w_sum = w_sum - (W+1)'(N);
          end
          idx_o   = w_sum[W-1:0];
          found_o = 1'b1;
        end
      end
    end else begin
      // Ascending index: the highest set index not above start_i wins.
      for (int k = 0; k < N; k++) begin
        if (vec_i[k] && ((W+1)'(k) <= {1'b0, start_i})) begin
          idx_o   = W'(k);
          found_o = 1'b1;
        end
      end
    end
  end

endmodule : prio_pick
`default_nettype wire

// File: rtl/rr_prio_encoder.sv
`default_nettype none
// ============================================================================
// Module  : rr_prio_encoder
// Purpose : Registered priority encoder with valid/ready output handshake.
//           MODE=0 picks the highest set request, MODE=1 rotates fairly
//           starting after the last accepted winner. One grant per cycle
//           when the consumer accepts continuously.
// Revision: 1.0 - initial release
// ============================================================================
module rr_prio_encoder
  import rr_prio_encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_multi
);

  localparam int W = $clog2(N);

  logic [0:0]   state_q, state_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         out_multi_q, out_multi_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         w_accept;
  logic [W-1:0] w_start;
  logic         w_wrap;
  logic [W-1:0] w_pick_idx;
  logic         w_found;
  logic         w_multi;

  assign out_valid  = (state_q == ST_HOLD);
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_multi  = out_multi_q;

  assign w_accept = out_valid & out_ready;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi  = |(req & (req - N'(1)));

  if (MODE == MODE_RR) begin : g_rr
    logic [W-1:0] w_base;
    // On a same-cycle recapture the pointer being written is the current winner.
    assign w_base  = w_accept ? out_idx_q : ptr_q;
    assign w_start = (w_base == W'(N - 1)) ? '0 : w_base + W'(1);
    assign w_wrap  = 1'b1;
  end else begin : g_fixed
    assign w_start = W'(N - 1);
    assign w_wrap  = 1'b0;
  end

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec_i   (req),
    .start_i (w_start),
    .wrap_i  (w_wrap),
    .idx_o   (w_pick_idx),
    .found_o (w_found)
  );

  // Next-state: capture when free or when the held winner is being accepted.
  always_comb begin
    state_d      = state_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_multi_d  = out_multi_q;
    ptr_d        = ptr_q;
    if (w_accept) begin
      ptr_d = out_idx_q;
    end
    if (w_found && ((state_q == ST_IDLE) || w_accept)) begin
      state_d      = ST_HOLD;
      out_idx_d    = w_pick_idx;
      out_onehot_d = N'(1) << w_pick_idx;
      out_multi_d  = w_multi;
    end else if (w_accept) begin
      state_d      = ST_IDLE;
      out_idx_d    = '0;
      out_onehot_d = '0;
      out_multi_d  = 1'b0;
    end
  end

  // State, output and pointer registers; reset parks ptr at N-1 so the first
  // round-robin search begins at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_multi_q  <= 1'b0;
      ptr_q        <= W'(N - 1);
    end else begin
      state_q      <= state_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_multi_q  <= out_multi_d;
      ptr_q        <= ptr_d;
    end
  end

endmodule : rr_prio_encoder
`default_nettype wire
